// File: rtl/adder_multiword_seq.sv
// Multi-limb add sequencer: feeds 32-bit limbs to an external combinational adder,
// chains carries between limbs and streams result limbs out with backpressure.
module adder_multiword_seq #(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_cin,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_cin,
    input  logic [31:0]      add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_carry,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic [15:0]      ops_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [31:0]      add_a_q, add_a_d;
    logic [31:0]      add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             iss_valid_q, iss_valid_d;
    logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;
    logic             out_last_q, out_last_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] in_idx_q, in_idx_d;
    logic [15:0]      ops_done_q, ops_done_d;

    logic advance;
    logic accept;
    logic capture;
    logic handoff;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = !reset && (!iss_valid_q || advance);
    assign accept   = in_valid && in_ready;
    assign capture  = iss_valid_q && advance;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        iss_valid_d = iss_valid_q;
        iss_idx_d   = iss_idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        carry_d     = carry_q;
        in_idx_d    = in_idx_q;
        ops_done_d  = ops_done_q;

        if (accept) begin
            add_a_d   = in_a;
            add_b_d   = in_b;
            iss_idx_d = in_idx_q;
            // Previous limb is either in the adder right now or already parked in carry_q.
            if (in_idx_q == '0) begin
                add_cin_d = in_cin;
            end else if (iss_valid_q) begin
                add_cin_d = add_carry;
            end else begin
                add_cin_d = carry_q;
            end
            in_idx_d = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + 1'b1;
        end

        if (capture) begin
            out_sum_d   = add_sum;
            out_idx_d   = iss_idx_q;
            out_last_d  = (iss_idx_q == LAST_IDX);
            out_carry_d = (iss_idx_q == LAST_IDX) ? add_carry : 1'b0;
            carry_d     = add_carry;
        end

        if (accept) begin
            iss_valid_d = 1'b1;
        end else if (capture) begin
            iss_valid_d = 1'b0;
        end

        if (capture) begin
            out_valid_d = 1'b1;
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end

        if (handoff && out_last_q && (ops_done_q != 16'hFFFF)) begin
            ops_done_d = ops_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            carry_q     <= 1'b0;
            in_idx_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            iss_valid_q <= iss_valid_d;
            iss_idx_q   <= iss_idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            carry_q     <= carry_d;
            in_idx_q    <= in_idx_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_adder_multiword_seq.sv
// Directed bench for adder_multiword_seq with a behavioural 32-bit adder attached.
module tb_adder_multiword_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_last;
    logic [1:0]  out_idx;
    logic [15:0] ops_done;

    int n_checks = 0;
    int n_errors = 0;

    // Result entries: {idx[1:0], last, carry, sum[31:0]}
    logic [35:0] res_q[$];

    adder_multiword_seq #(.WORDS(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_carry(add_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_last(out_last),
        .out_idx(out_idx), .ops_done(ops_done)
    );

    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            res_q.push_back({out_idx, out_last, out_carry, out_sum});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_limb(input logic [31:0] a, input logic [31:0] b, input logic cin);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            n_errors++;
            $display("FAIL accept_timeout observed=in_ready_low expected=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [127:0] a, input logic [127:0] b, input logic cin,
                           input int gap);
        for (int i = 0; i < 4; i++) begin
            send_limb(a[32*i +: 32], b[32*i +: 32], cin);
            if (i == 0) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_results(input string tag, input int n);
        int k = 0;
        while (res_q.size() < n && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, res_q.size(), n);
    endtask

    task automatic check_op(input string tag, input logic [127:0] s, input logic c);
        logic [35:0] e;
        for (int i = 0; i < 4; i++) begin
            e = (res_q.size() > 0) ? res_q.pop_front() : 36'hF_FFFF_FFFF;
            chk({tag, "_idx"}, e[35:34], i);
            chk({tag, "_last"}, e[33], (i == 3));
            chk({tag, "_carry"}, e[32], (i == 3) ? c : 1'b0);
            chk({tag, "_sum"}, e[31:0], s[32*i +: 32]);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_add_a", add_a, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic op with cin=1
        send_op({96'd0, 32'd123}, {96'd0, 32'd456}, 1'b1, 0);
        wait_results("t1_count", 4);
        check_op("t1", {96'd0, 32'd580}, 1'b0);
        chk("t1_ops", ops_done, 1);

        // Carry ripples through every limb
        send_op({4{32'hFFFF_FFFF}}, {96'd0, 32'd1}, 1'b0, 0);
        wait_results("t2_count", 4);
        check_op("t2", 128'd0, 1'b1);
        chk("t2_ops", ops_done, 2);

        // Same op with a 5-cycle output stall
        fork
            send_op({4{32'hFFFF_FFFF}}, {96'd0, 32'd1}, 1'b0, 0);
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 50);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_in_ready", in_ready, 0);
                    chk("t3_out_valid", out_valid, 1);
                    chk("t3_out_sum", out_sum, 0);
                    chk("t3_out_idx", out_idx, 0);
                    chk("t3_add_a", add_a, 32'hFFFF_FFFF);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results("t3_count", 4);
        check_op("t3", 128'd0, 1'b1);
        chk("t3_ops", ops_done, 3);

        // Bubble after limb 0: carry must come from carry_reg
        send_op({64'd0, 32'd5, 32'h8000_0000}, {64'd0, 32'd7, 32'h8000_0000}, 1'b0, 3);
        wait_results("t4_count", 4);
        check_op("t4", {64'd0, 32'd13, 32'd0}, 1'b0);
        chk("t4_ops", ops_done, 4);

        // Reset mid-operation
        send_limb(32'h11, 32'h22, 1'b1);
        send_limb(32'h55, 32'h66, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_add_a", add_a, 0);
        chk("t5_add_b", add_b, 0);
        chk("t5_add_cin", add_cin, 0);
        chk("t5_out_sum", out_sum, 0);
        chk("t5_out_idx", out_idx, 0);
        chk("t5_out_last", out_last, 0);
        chk("t5_ops", ops_done, 0);
        reset = 1'b0;
        res_q.delete();
        send_op({96'd0, 32'd1}, {96'd0, 32'd2}, 1'b0, 0);
        wait_results("t5_count", 4);
        check_op("t5", {96'd0, 32'd3}, 1'b0);
        chk("t5_ops_after", ops_done, 1);

        // Back-to-back ops: op1 carry-out must not reach op2
        send_op({4{32'hFFFF_FFFF}}, {96'd0, 32'd1}, 1'b0, 0);
        send_op({96'd0, 32'd10}, {96'd0, 32'd20}, 1'b0, 0);
        wait_results("t6_count", 8);
        check_op("t6_op1", 128'd0, 1'b1);
        check_op("t6_op2", {96'd0, 32'd30}, 1'b0);
        chk("t6_ops", ops_done, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
